// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS pattern generator and its far-end reference copy.
package prbs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } prbs_state_t;

  localparam int LEN_W = 16;

  // Maximal-length feedback masks for the left-shifting LFSR, indexed by width.
  // Bit i set means state[i] takes part in the feedback XOR.
  localparam logic [15:0] DEFAULT_TAPS [3:16] = '{
    16'h0006, 16'h000C, 16'h0014, 16'h0030, 16'h0060, 16'h00B8, 16'h0110,
    16'h0240, 16'h0500, 16'h0E08, 16'h1C80, 16'h3802, 16'h6000, 16'hD008
  };

  // Default mask for a given width; zero when the width has no table entry.
  function automatic logic [15:0] default_taps(input int n);
    logic [15:0] t;
    t = 16'h0000;
    for (int i = 3; i <= 16; i++) begin
      if (i == n) t = DEFAULT_TAPS[i];
    end
    return t;
  endfunction

endpackage

// File: rtl/prbs_lfsr.sv
// N-bit left-shifting LFSR register with load and step controls.
// Shared between the transmit generator and the far-end reference generator.
// An all-zero seed would lock the register, so it is replaced by all-ones.
module prbs_lfsr #(
  parameter int            N    = 8,
  parameter logic [N-1:0]  TAPS = 8'hB8,
  parameter logic [N-1:0]  SEED = 8'h01
) (
  input  logic         clock,
  input  logic         n_reset,
  input  logic         load,
  input  logic         step,
  input  logic [N-1:0] seed,
  output logic [N-1:0] state
);

  localparam logic [N-1:0] RESET_VAL = (SEED == '0) ? '1 : SEED;

  logic [N-1:0] state_next;
  logic [N-1:0] seed_fixed;

  // Step function: shift left, feedback is the parity of the tapped bits.
  always_comb begin
    state_next = {state[N-2:0], ^(state & TAPS)};
    seed_fixed = (seed == '0) ? '1 : seed;
  end

  // State register: load has priority over step.
  always_ff @(posedge clock) begin
    if (!n_reset) begin
      state <= RESET_VAL;
    end else if (load) begin
      state <= seed_fixed;
    end else if (step) begin
      state <= state_next;
    end
  end

endmodule

// File: rtl/prbs_pattern_gen.sv
// PRBS word-stream transmitter with valid/ready handshake.
// Runs for a programmed word count (len != 0) or continuously (len == 0).
// Optional error injection (bit 0 flip on one word) when PRBS_ERR_INJECT_EN is defined.
module prbs_pattern_gen
  import prbs_pkg::*;
#(
  parameter int            N    = 8,
  parameter logic [N-1:0]  TAPS = 8'hB8,
  parameter logic [N-1:0]  SEED = 8'h01
) (
  input  logic             clock,
  input  logic             n_reset,
  input  logic             start,
  input  logic             stop,
  input  logic [LEN_W-1:0] len,
  output logic [N-1:0]     data_out,
  output logic             valid,
  input  logic             ready,
  output logic             busy,
  output logic             done
`ifdef PRBS_ERR_INJECT_EN
  ,
  input  logic             inj_req,
  output logic             inj_ack
`endif
);

  prbs_state_t      state_reg;
  prbs_state_t      state_next;
  logic [LEN_W-1:0] count_reg;
  logic             cont_reg;
  logic [N-1:0]     last_reg;
  logic [N-1:0]     lfsr_state;
  logic [N-1:0]     word;
  logic             accept;
  logic             lfsr_load;
  logic             start_ok;

  assign accept   = (state_reg == RUN) && ready;
  assign start_ok = (state_reg == IDLE) && start && !stop;

  prbs_lfsr #(
    .N    (N),
    .TAPS (TAPS),
    .SEED (SEED)
  ) u_lfsr (
    .clock   (clock),
    .n_reset (n_reset),
    .load    (lfsr_load),
    .step    (accept),
    .seed    (SEED),
    .state   (lfsr_state)
  );

`ifdef PRBS_ERR_INJECT_EN
  logic armed_reg;

  // One-shot injection flag: cleared by stop or by the corrupted word being taken.
  always_ff @(posedge clock) begin
    if (!n_reset) begin
      armed_reg <= 1'b0;
    end else if (stop) begin
      armed_reg <= 1'b0;
    end else if (armed_reg && accept) begin
      armed_reg <= 1'b0;
    end else if (inj_req) begin
      armed_reg <= 1'b1;
    end
  end

  // The outgoing word is corrupted; the LFSR itself keeps the clean sequence.
  always_comb begin
    word    = lfsr_state ^ {{(N-1){1'b0}}, armed_reg};
    inj_ack = armed_reg && accept;
  end
`else
  // Without injection the outgoing word is the LFSR state itself.
  always_comb begin
    word = lfsr_state;
  end
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (!n_reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: stop beats start, and stop beats a final-word completion.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start_ok) state_next = LOAD;
      LOAD: state_next = RUN;
      RUN: begin
        if (stop) begin
          state_next = IDLE;
        end else if (accept && !cont_reg && (count_reg == LEN_W'(1))) begin
          state_next = DONE;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: data_out shows the live word in RUN and holds the last one elsewhere.
  always_comb begin
    valid     = (state_reg == RUN);
    busy      = (state_reg == LOAD) || (state_reg == RUN);
    done      = (state_reg == DONE);
    lfsr_load = (state_reg == LOAD);
    data_out  = (state_reg == RUN) ? word : last_reg;
  end

  // Word counter: length captured when a run is launched, decremented per accepted word.
  always_ff @(posedge clock) begin
    if (!n_reset) begin
      count_reg <= '0;
      cont_reg  <= 1'b0;
    end else if (start_ok) begin
      count_reg <= len;
      cont_reg  <= (len == '0);
    end else if (accept && !cont_reg) begin
      count_reg <= count_reg - LEN_W'(1);
    end
  end

  // Last displayed word, so data_out keeps its value once the run ends.
  always_ff @(posedge clock) begin
    if (!n_reset) begin
      last_reg <= '0;
    end else if (state_reg == RUN) begin
      last_reg <= word;
    end
  end

endmodule

// File: tb/tb_prbs_pattern_gen.sv
// Self-checking bench for prbs_pattern_gen (N=8, TAPS=8'hB8, SEED=8'h01).
// Define PRBS_ERR_INJECT_EN to also exercise the error-injection ports.
module tb_prbs_pattern_gen;

  localparam logic [7:0] TAPS = 8'hB8;
  localparam logic [7:0] SEED = 8'h01;

  logic        clock = 1'b0;
  logic        n_reset;
  logic        start;
  logic        stop;
  logic [15:0] len;
  logic [7:0]  data_out;
  logic        valid;
  logic        ready;
  logic        busy;
  logic        done;
`ifdef PRBS_ERR_INJECT_EN
  logic        inj_req;
  logic        inj_ack;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  prbs_pattern_gen #(
    .N    (8),
    .TAPS (TAPS),
    .SEED (SEED)
  ) dut (
    .clock    (clock),
    .n_reset  (n_reset),
    .start    (start),
    .stop     (stop),
    .len      (len),
    .data_out (data_out),
    .valid    (valid),
    .ready    (ready),
    .busy     (busy),
    .done     (done)
`ifdef PRBS_ERR_INJECT_EN
    ,
    .inj_req  (inj_req),
    .inj_ack  (inj_ack)
`endif
  );

  // Reference: k-th word of the sequence, from the seed and the parity feedback rule.
  function automatic logic [7:0] model_word(input int k);
    logic [7:0] w;
    w = SEED;
    for (int i = 0; i < k; i++) begin
      w = {w[6:0], ($countones(w & TAPS) % 2) == 1};
    end
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One run: returns number of accepted words and whether done was seen.
  task automatic do_run(input int rlen, input int stall_pct, input int stop_after,
                        input string tag, output int acc, output bit dn);
    int cyc;
    bit was_stalled;
    bit finished;
    logic [7:0] held;
    acc = 0; cyc = 0; was_stalled = 0; finished = 0; held = '0; dn = 0;
    len = 16'(rlen); start = 1'b1; stop = 1'b0; ready = 1'b0;
    tick();
    start = 1'b0;
    chk({tag, "_load"}, {29'b0, busy, valid, done}, 32'h4);
    tick();
    while (!finished && cyc < 500) begin
      chk({tag, "_valid"}, {31'b0, valid}, 32'h1);
      if (was_stalled) chk({tag, "_hold"}, {24'b0, data_out}, {24'b0, held});
      ready = (stall_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= stall_pct);
      if (stop_after != 0 && acc == stop_after - 1) begin
        ready = 1'b1;
        stop  = 1'b1;
      end
      if (ready) begin
        chk({tag, "_word"}, {24'b0, data_out}, {24'b0, model_word(acc)});
        acc++;
        if (stop) finished = 1;
        else if (rlen != 0 && acc == rlen) finished = 1;
      end
      was_stalled = !ready;
      held = data_out;
      tick();
      stop = 1'b0;
      cyc++;
    end
    ready = 1'b0;
    if (!finished) chk({tag, "_timeout"}, 32'h0, 32'h1);
    dn = done;
    chk({tag, "_after_valid"}, {31'b0, valid}, 32'h0);
    if (dn) begin
      tick();
      chk({tag, "_done_width"}, {31'b0, done}, 32'h0);
    end
    chk({tag, "_idle_busy"}, {31'b0, busy}, 32'h0);
    if (acc > 0) chk({tag, "_last_hold"}, {24'b0, data_out}, {24'b0, model_word(acc - 1)});
    $display("run %s: len=%0d stall=%0d stop_after=%0d accepts=%0d done=%0d",
             tag, rlen, stall_pct, stop_after, acc, dn);
  endtask

  typedef struct {
    int len;
    int stall_pct;
    int stop_after;
    int exp_acc;
    bit exp_done;
  } vec_t;

  initial begin
    vec_t vecs [8];
    logic [7:0] exp1 [6];
    int acc;
    bit dn;

    vecs[0] = '{6,  0,  0,  6, 1};
    vecs[1] = '{4,  50, 0,  4, 1};
    vecs[2] = '{1,  0,  0,  1, 1};
    vecs[3] = '{0,  0,  10, 10, 0};
    vecs[4] = '{0,  30, 7,  7, 0};
    vecs[5] = '{3,  0,  2,  2, 0};
    vecs[6] = '{12, 40, 0,  12, 1};
    vecs[7] = '{2,  0,  2,  2, 0};
    exp1 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23};

    n_reset = 1'b0; start = 1'b0; stop = 1'b0; ready = 1'b0; len = '0;
`ifdef PRBS_ERR_INJECT_EN
    inj_req = 1'b0;
`endif
    tick(); tick();
    chk("reset_outs", {21'b0, data_out, valid, busy, done}, 32'h0);
    n_reset = 1'b1;
    tick();
    chk("idle_outs", {21'b0, data_out, valid, busy, done}, 32'h0);

    // Exact sequence, back-to-back, with first-valid latency.
    len = 16'd6; start = 1'b1; ready = 1'b1;
    tick();
    start = 1'b0;
    chk("seq_lat_load", {31'b0, valid}, 32'h0);
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("seq_valid", {31'b0, valid}, 32'h1);
      chk("seq_word", {24'b0, data_out}, {24'b0, exp1[i]});
      tick();
    end
    chk("seq_done", {30'b0, done, valid}, 32'h2);
    tick();
    chk("seq_idle", {29'b0, done, busy, valid}, 32'h0);
    ready = 1'b0;
    $display("run exact_seq: 6 words checked");

    // Table-driven runs.
    for (int v = 0; v < 8; v++) begin
      do_run(vecs[v].len, vecs[v].stall_pct, vecs[v].stop_after, $sformatf("vec%0d", v), acc, dn);
      chk($sformatf("vec%0d_acc", v), 32'(acc), 32'(vecs[v].exp_acc));
      chk($sformatf("vec%0d_done", v), {31'b0, dn}, {31'b0, vecs[v].exp_done});
    end

    // Reset in the middle of a continuous run.
    len = 16'd0; start = 1'b1; ready = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("midrst_word", {24'b0, data_out}, {24'b0, model_word(2)});
    n_reset = 1'b0;
    tick();
    chk("midrst_outs", {21'b0, data_out, valid, busy, done}, 32'h0);
    n_reset = 1'b1; ready = 1'b0;
    tick();
    chk("midrst_nodone", {31'b0, done}, 32'h0);
    $display("run mid_reset: outputs cleared");
    do_run(2, 0, 0, "after_rst", acc, dn);
    chk("after_rst_acc", 32'(acc), 32'd2);

    // start together with stop in IDLE stays idle.
    start = 1'b1; stop = 1'b1; len = 16'd3;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("startstop_busy", {30'b0, busy, valid}, 32'h0);
    tick();
    chk("startstop_busy2", {30'b0, busy, valid}, 32'h0);
    $display("run start_stop: stayed idle");

    // start while busy is ignored and the run length is unchanged.
    len = 16'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    len = 16'd9; start = 1'b1; ready = 1'b0;
    tick();
    start = 1'b0; ready = 1'b1;
    acc = 0; dn = 0;
    for (int c = 0; c < 30 && !dn; c++) begin
      if (valid && ready) acc++;
      tick();
      dn = done;
    end
    ready = 1'b0;
    chk("busy_start_acc", 32'(acc), 32'd3);
    chk("busy_start_done", {31'b0, dn}, 32'h1);
    tick();
    $display("run start_while_busy: accepts=%0d", acc);

`ifdef PRBS_ERR_INJECT_EN
    // Injection: word 3 has bit 0 flipped, second request while armed is absorbed.
    begin
      int acks;
      acks = 0;
      len = 16'd5; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      ready = 1'b1;
      chk("inj_w0", {24'b0, data_out}, 32'h01);
      tick();
      inj_req = 1'b1;
      chk("inj_w1", {24'b0, data_out}, 32'h02);
      tick();
      chk("inj_w2", {24'b0, data_out}, 32'h05);
      chk("inj_ack", {31'b0, inj_ack}, 32'h1);
      acks++;
      tick();
      inj_req = 1'b0;
      chk("inj_w3", {24'b0, data_out}, 32'h08);
      if (inj_ack) acks++;
      tick();
      chk("inj_w4", {24'b0, data_out}, 32'h11);
      if (inj_ack) acks++;
      tick();
      ready = 1'b0;
      chk("inj_done", {31'b0, done}, 32'h1);
      chk("inj_acks", 32'(acks), 32'd1);
      tick();
      $display("run inject: acks=%0d", acks);
    end
`endif

    // Randomized runs checked against the reference model.
    for (int r = 0; r < 8; r++) begin
      int rl, sp, sa;
      rl = $urandom_range(1, 15);
      sp = $urandom_range(0, 60);
      sa = ($urandom_range(0, 2) == 0) ? $urandom_range(1, rl) : 0;
      do_run(rl, sp, sa, $sformatf("rnd%0d", r), acc, dn);
      chk($sformatf("rnd%0d_acc", r), 32'(acc), 32'((sa != 0) ? sa : rl));
      chk($sformatf("rnd%0d_done", r), {31'b0, dn}, {31'b0, (sa == 0)});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
